// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues one 4-byte read at a time on the
// imem port and hands the returned word to decode over a valid/ready handshake.
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  output logic [2:0]  imem_req_size,
  input  logic        imem_resp_valid,
  output logic        imem_resp_ready,
  input  logic [63:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_req_addr;
  logic [63:0] r_inst_pc;
  logic [31:0] r_inst;
  logic        r_drop;
  logic        r_fault;
  logic        r_req_valid;
  logic        r_resp_ready;
  logic        r_inst_valid;

  logic        w_xfer;
  logic        w_resp_hs;
  logic        w_launch;
  logic [63:0] w_launch_pc;
  logic [31:0] w_word;

  assign w_xfer    = r_inst_valid & inst_ready & ~stall;
  assign w_resp_hs = r_resp_ready & imem_resp_valid;
  assign w_word    = r_pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];

  // A launch starts a fresh fetch at w_launch_pc; redirect beats transfer in HOLD.
  always_comb begin
    w_launch    = 1'b0;
    w_launch_pc = r_pc;
    case (r_state)
      S_IDLE: begin
        w_launch = 1'b1;
        if (redirect_valid) w_launch_pc = redirect_pc;
      end
      S_WAIT: begin
        if (w_resp_hs && (redirect_valid || r_drop)) begin
          w_launch = 1'b1;
          if (redirect_valid) w_launch_pc = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_launch    = 1'b1;
          w_launch_pc = redirect_pc;
        end else if (w_xfer) begin
          w_launch    = 1'b1;
          w_launch_pc = r_pc + 64'd4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_drop       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_resp_ready <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= 64'd0;
      r_fault      <= 1'b0;
    end else if (w_launch) begin
      r_pc         <= w_launch_pc;
      r_drop       <= 1'b0;
      r_resp_ready <= 1'b0;
      if (w_launch_pc[1:0] == 2'b00) begin
        r_state      <= S_REQ;
        r_req_valid  <= 1'b1;
        r_inst_valid <= 1'b0;
        r_req_addr   <= w_launch_pc;
      end else if (r_state == S_IDLE) begin
        r_state      <= S_HOLD;
        r_req_valid  <= 1'b0;
        r_inst_valid <= 1'b1;
        r_inst       <= NOP_INST;
        r_inst_pc    <= w_launch_pc;
        r_fault      <= 1'b1;
      end else begin
        // Misaligned target: pass through IDLE so inst_valid drops for a cycle.
        r_state      <= S_IDLE;
        r_req_valid  <= 1'b0;
        r_inst_valid <= 1'b0;
      end
    end else begin
      // Only REQ/WAIT get here with a redirect: the in-flight read becomes stale.
      if (redirect_valid) begin
        r_pc   <= redirect_pc;
        r_drop <= 1'b1;
      end
      case (r_state)
        S_REQ: begin
          if (imem_req_ready) begin
            r_state      <= S_WAIT;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_resp_hs) begin
            r_state      <= S_HOLD;
            r_resp_ready <= 1'b0;
            r_inst_valid <= 1'b1;
            r_inst       <= imem_resp_err ? NOP_INST : w_word;
            r_inst_pc    <= r_pc;
            r_fault      <= imem_resp_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid  = r_req_valid;
  assign imem_req_addr   = r_req_addr;
  assign imem_req_size   = 3'b010;
  assign imem_resp_ready = r_resp_ready;
  assign inst_valid      = r_inst_valid;
  assign inst            = r_inst;
  assign inst_pc         = r_inst_pc;
  assign fetch_fault     = r_fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios, then random traffic checked
// against an architectural PC/instruction-stream model and a memory model.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic [2:0]  imem_req_size;
  logic        imem_resp_valid = 1'b0;
  logic        imem_resp_ready;
  logic [63:0] imem_resp_data = 64'd0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_fault;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_req_size(imem_req_size),
    .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory model state
  logic [63:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rnd_ready = 0;
  bit          rnd_err = 0;
  logic [63:0] err_addr = 64'h1;
  int          n_req = 0, n_resp = 0, n_reqv = 0;

  function automatic logic [31:0] hw(input logic [63:0] x);
    return (x[31:0] * 32'h9E37_79B1) ^ x[63:32] ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [63:0] beat(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    if (b == 64'h8000_0000) return 64'h00A0_0093_0000_0013;
    return {hw(b | 64'd4), hw(b)};
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] a);
    logic [63:0] d;
    d = beat(a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  function automatic bit exp_err(input logic [63:0] a);
    return (a == err_addr) || (rnd_err && a[6:2] == 5'd7);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (imem_req_valid) n_reqv++;
      if (imem_resp_valid && imem_resp_ready) begin
        n_resp++;
        if (q_addr.size() > 0) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        n_req++;
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat - 1);
      end
    end
  end

  always @(negedge clk) begin
    imem_req_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
    if (q_addr.size() > 0 && cyc >= q_due[0]) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = beat(q_addr[0]);
      imem_resp_err   = exp_err(q_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      imem_resp_err   = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output logic [63:0] a, output bit ok);
    ok = 0;
    a = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (imem_req_valid === 1'b1) begin
        ok = 1;
        a = imem_req_addr;
      end else @(negedge clk);
    end
  endtask

  task automatic wait_inst(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (inst_valid === 1'b1) ok = 1;
      else @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [63:0] a, rpc, exp_pc, hold_pc;
  logic [31:0] hold_inst;
  bit          ok, ef;
  int          nv, xfers;

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; stall = 0; inst_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_resp_ready", imem_resp_ready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("req_size", imem_req_size, 3'b010);
    rst = 0;

    wait_req(a, ok); chk("req0_seen", ok, 1);
    chk("req0_addr", a, 64'h8000_0000);
    chk("req0_resp_ready", imem_resp_ready, 0);
    wait_inst(ok); chk("inst0_seen", ok, 1);
    chk("inst0", inst, 32'h0000_0013);
    chk("inst0_pc", inst_pc, 64'h8000_0000);
    chk("inst0_fault", fetch_fault, 0);
    inst_ready = 1; @(negedge clk); inst_ready = 0;
    chk("xfer0_valid_drop", inst_valid, 0);
    chk("req1_valid", imem_req_valid, 1);
    chk("req1_addr", imem_req_addr, 64'h8000_0004);
    wait_inst(ok); chk("inst1_seen", ok, 1);
    chk("inst1", inst, 32'h00A0_0093);
    chk("inst1_pc", inst_pc, 64'h8000_0004);

    // stalled hold
    hold_inst = 32'h00A0_0093; hold_pc = 64'h8000_0004;
    stall = 1; inst_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, hold_inst);
      chk("hold_pc", inst_pc, hold_pc);
    end
    stall = 0; @(negedge clk); inst_ready = 0;
    chk("hold_xfer_drop", inst_valid, 0);
    chk("req2_valid", imem_req_valid, 1);
    chk("req2_addr", imem_req_addr, 64'h8000_0008);

    // redirect while waiting on a slow response
    lat = 4; @(negedge clk);
    chk("wait_resp_ready", imem_resp_ready, 1);
    redirect_valid = 1; redirect_pc = 64'h8000_1000; @(negedge clk);
    redirect_valid = 0; lat = 1;
    wait_req(a, ok); chk("redir_wait_seen", ok, 1);
    chk("redir_wait_addr", a, 64'h8000_1000);
    chk("redir_wait_balanced", n_resp, n_req);
    wait_inst(ok); chk("redir_wait_inst_seen", ok, 1);
    chk("redir_wait_pc", inst_pc, 64'h8000_1000);
    chk("redir_wait_inst", inst, exp_word(64'h8000_1000));

    // redirect and transfer in the same cycle
    inst_ready = 1; redirect_valid = 1; redirect_pc = 64'h8000_0100; @(negedge clk);
    inst_ready = 0; redirect_valid = 0;
    chk("redir_hold_valid", inst_valid, 0);
    chk("redir_hold_req", imem_req_valid, 1);
    chk("redir_hold_addr", imem_req_addr, 64'h8000_0100);
    wait_inst(ok); chk("redir_hold_inst_seen", ok, 1);
    chk("redir_hold_pc", inst_pc, 64'h8000_0100);

    // bus error
    err_addr = 64'h8000_0104;
    inst_ready = 1; @(negedge clk); inst_ready = 0;
    wait_inst(ok); chk("err_seen", ok, 1);
    chk("err_inst", inst, NOP);
    chk("err_fault", fetch_fault, 1);
    chk("err_pc", inst_pc, 64'h8000_0104);

    // misaligned redirect
    nv = n_reqv;
    redirect_valid = 1; redirect_pc = 64'h8000_0002; @(negedge clk); redirect_valid = 0;
    chk("mis_bubble", inst_valid, 0);
    wait_inst(ok); chk("mis_seen", ok, 1);
    chk("mis_fault", fetch_fault, 1);
    chk("mis_inst", inst, NOP);
    chk("mis_pc", inst_pc, 64'h8000_0002);
    chk("mis_noreq", n_reqv, nv);

    // pc wrap
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; @(negedge clk); redirect_valid = 0;
    wait_inst(ok); chk("wrap_seen", ok, 1);
    chk("wrap_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_fault", fetch_fault, 0);
    inst_ready = 1; @(negedge clk); inst_ready = 0;
    wait_req(a, ok); chk("wrap_req_seen", ok, 1);
    chk("wrap_addr", a, 64'd0);
    wait_inst(ok); chk("wrap0_seen", ok, 1);
    chk("wrap0_pc", inst_pc, 64'd0);

    // random traffic against the instruction-stream model
    exp_pc = 64'd0; err_addr = 64'h1; rnd_ready = 1; rnd_err = 1; xfers = 0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 29) == 0);
      if (redirect_valid) begin
        rpc = {$urandom, $urandom};
        if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
        redirect_pc = rpc;
        exp_pc = rpc;
      end else if (inst_valid && inst_ready && !stall) begin
        ef = (exp_pc[1:0] != 2'b00) || exp_err(exp_pc);
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_fault", fetch_fault, ef);
        chk("rnd_inst", inst, ef ? NOP : exp_word(exp_pc));
        exp_pc = exp_pc + 64'd4;
        xfers++;
      end
      @(negedge clk);
    end
    redirect_valid = 0; stall = 0; inst_ready = 0;
    wait_inst(ok); chk("rnd_settle", ok, 1);
    chk("rnd_settle_pc", inst_pc, exp_pc);
    chk("rnd_balanced", n_resp, n_req);
    chk("rnd_progress", xfers > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
